// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register address width, ALU opcodes,
// tracked stage entry layout and forward-select encoding.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_STAGES = 3;

  typedef enum logic [2:0] {
    ADD  = 3'b001,
    SUB  = 3'b010,
    NAND = 3'b011,
    NOR  = 3'b100
  } opcode_t;

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] dest;
    logic                  we;
    logic                  ld;
  } stage_entry_t;

  // 0 = register file, k+1 = forward from tracked stage k
  typedef logic [$clog2(NUM_STAGES+1)-1:0] fwd_sel_t;

endpackage

// File: rtl/hazard_match.sv
// Priority comparator of one ID source operand against all tracked stages;
// the youngest (lowest-index) matching stage decides hazard and forward select.
module hazard_match #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned LOAD_STAGE = 1,
  parameter bit          FWD_EN     = 1'b0
) (
  input  logic [REG_ADDR_W-1:0]                  src,
  input  logic                                   use_src,
  input  logic [NUM_STAGES-1:0]                  ent_v,
  input  logic [NUM_STAGES-1:0]                  ent_we,
  input  logic [NUM_STAGES-1:0]                  ent_ld,
  input  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0]  ent_dest,
  output logic                                   hazard,
  output logic [$clog2(NUM_STAGES+1)-1:0]        fwd
);
  import pipe_pkg::*;

  localparam int unsigned FWD_W = $clog2(NUM_STAGES + 1);

  logic found;

  always_comb begin
    hazard = 1'b0;
    fwd    = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (!found && use_src && (src != '0) && ent_v[k] && ent_we[k] &&
          (ent_dest[k] == src)) begin
        found  = 1'b1;
        // Without forwarding every in-flight write blocks; with it only an
        // early-stage load whose data does not exist yet.
        hazard = FWD_EN ? (ent_ld[k] && (k < LOAD_STAGE)) : 1'b1;
        fwd    = FWD_EN ? FWD_W'(k + 1) : '0;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection, forward-select and stall unit over a shift register of
// in-flight writes. Forwarding is enabled by defining HAZARD_FWD_EN.
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned LOAD_STAGE = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             id_valid,
  input  logic [REG_ADDR_W-1:0]            id_src_a,
  input  logic [REG_ADDR_W-1:0]            id_src_b,
  input  logic                             id_use_a,
  input  logic                             id_use_b,
  input  logic [REG_ADDR_W-1:0]            id_dest,
  input  logic                             id_we,
  input  logic                             id_is_load,
  input  logic                             flush,
  output logic                             issue,
  output logic                             stall,
  output logic [$clog2(NUM_STAGES+1)-1:0]  fwd_a,
  output logic [$clog2(NUM_STAGES+1)-1:0]  fwd_b,
  output logic [CNT_W-1:0]                 stall_cnt
);
  import pipe_pkg::*;

  localparam int unsigned FWD_W = $clog2(NUM_STAGES + 1);
`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] dest;
    logic                  we;
    logic                  ld;
  } entry_t;

  entry_t [NUM_STAGES-1:0] entry_q, entry_d;
  logic   [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic [NUM_STAGES-1:0]                 ent_v, ent_we, ent_ld;
  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] ent_dest;
  logic                                  hazard_a, hazard_b;
  logic [FWD_W-1:0]                      fwd_raw_a, fwd_raw_b;

  always_comb begin
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      ent_v[k]    = entry_q[k].v;
      ent_we[k]   = entry_q[k].we;
      ent_ld[k]   = entry_q[k].ld;
      ent_dest[k] = entry_q[k].dest;
    end
  end

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_STAGES (NUM_STAGES),
    .LOAD_STAGE (LOAD_STAGE),
    .FWD_EN     (FWD_EN)
  ) u_match_a (
    .src      (id_src_a),
    .use_src  (id_use_a),
    .ent_v    (ent_v),
    .ent_we   (ent_we),
    .ent_ld   (ent_ld),
    .ent_dest (ent_dest),
    .hazard   (hazard_a),
    .fwd      (fwd_raw_a)
  );

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_STAGES (NUM_STAGES),
    .LOAD_STAGE (LOAD_STAGE),
    .FWD_EN     (FWD_EN)
  ) u_match_b (
    .src      (id_src_b),
    .use_src  (id_use_b),
    .ent_v    (ent_v),
    .ent_we   (ent_we),
    .ent_ld   (ent_ld),
    .ent_dest (ent_dest),
    .hazard   (hazard_b),
    .fwd      (fwd_raw_b)
  );

  always_comb begin
    stall = id_valid & ~flush & (hazard_a | hazard_b);
    issue = id_valid & ~flush & ~stall;
    fwd_a = issue ? fwd_raw_a : '0;
    fwd_b = issue ? fwd_raw_b : '0;
  end

  always_comb begin
    entry_d = entry_q;
    for (int unsigned k = 1; k < NUM_STAGES; k++) begin
      entry_d[k] = entry_q[k-1];
    end
    entry_d[0] = issue ? '{v: 1'b1, dest: id_dest, we: id_we, ld: id_is_load} : '0;
    if (flush) begin
      entry_d = '0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      entry_q     <= entry_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow HAZARD_FWD_EN.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned NS = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned FW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_src_a, id_src_b, id_dest;
  logic          id_use_a, id_use_b, id_we, id_is_load;
  logic          flush;
  logic          issue, stall;
  logic [FW-1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int total   = 0;
  int n       = 0;
  int iter    = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_ADDR_W (AW),
    .NUM_STAGES (NS),
    .LOAD_STAGE (1),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_src_a   (id_src_a),
    .id_src_b   (id_src_b),
    .id_use_a   (id_use_a),
    .id_use_b   (id_use_b),
    .id_dest    (id_dest),
    .id_we      (id_we),
    .id_is_load (id_is_load),
    .flush      (flush),
    .issue      (issue),
    .stall      (stall),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stall_cnt  (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_id(input logic v, input int sa, input logic ua, input int sb,
                        input logic ub, input int d, input logic we, input logic ld);
    id_valid   = v;
    id_src_a   = AW'(sa);
    id_use_a   = ua;
    id_src_b   = AW'(sb);
    id_use_b   = ub;
    id_dest    = AW'(d);
    id_we      = we;
    id_is_load = ld;
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < int'(NS); i++) step();
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Reset state
    set_id(1'b1, 1, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0);
    check("rst_issue", issue, 1);
    check("rst_stall", stall, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
    check("rst_cnt", stall_cnt, 0);
    step();

    // ADD r3 = r2 + r1 ; SUB r6 = r5 - r3
    set_id(1'b1, 2, 1'b1, 1, 1'b1, 3, 1'b1, 1'b0);
    check("add_issue", issue, 1);
    step();
    set_id(1'b1, 5, 1'b1, 3, 1'b1, 6, 1'b1, 1'b0);
`ifdef HAZARD_FWD_EN
    check("ex_fwd_issue", issue, 1);
    check("ex_fwd_stall", stall, 0);
    check("ex_fwd_b", fwd_b, 1);
    check("ex_fwd_a", fwd_a, 0);
`else
    for (int i = 0; i < 3; i++) begin
      check("ex_nofwd_stall", stall, 1);
      check("ex_nofwd_issue0", issue, 0);
      step();
      exp_cnt++;
    end
    check("ex_nofwd_issue", issue, 1);
    check("ex_nofwd_stall_end", stall, 0);
    check("ex_nofwd_fwd_b", fwd_b, 0);
`endif
    step();
    check("ex_cnt", stall_cnt, sat(exp_cnt));

    // Load-use: LD r4 ; ADD r7 = r4 + r1
    drain();
    set_id(1'b1, 1, 1'b0, 0, 1'b0, 4, 1'b1, 1'b1);
    step();
    set_id(1'b1, 4, 1'b1, 1, 1'b1, 7, 1'b1, 1'b0);
`ifdef HAZARD_FWD_EN
    check("lu_stall", stall, 1);
    check("lu_issue0", issue, 0);
    check("lu_fwd_a_stalled", fwd_a, 0);
    step();
    exp_cnt++;
    check("lu_issue", issue, 1);
    check("lu_fwd_a", fwd_a, 2);
    check("lu_fwd_b", fwd_b, 0);
`else
    for (int i = 0; i < 3; i++) begin
      check("lu_stall", stall, 1);
      step();
      exp_cnt++;
    end
    check("lu_issue", issue, 1);
    check("lu_fwd_a", fwd_a, 0);
`endif
    step();
    check("lu_cnt", stall_cnt, sat(exp_cnt));

    // Register 0: ADD r0 = r1 + r2 ; NAND r8 = r0, r0
    drain();
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 0, 1'b1, 1'b0);
    step();
    set_id(1'b1, 0, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0);
    check("r0_stall", stall, 0);
    check("r0_issue", issue, 1);
    check("r0_fwd_a", fwd_a, 0);
    check("r0_fwd_b", fwd_b, 0);
    step();

    // Same source on A and B, producer in MEM
    drain();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0);
    step();
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5, 1'b1, 5, 1'b1, 9, 1'b1, 1'b0);
`ifdef HAZARD_FWD_EN
    check("same_issue", issue, 1);
    check("same_fwd_a", fwd_a, 2);
    check("same_fwd_b", fwd_b, 2);
`else
    for (int i = 0; i < 2; i++) begin
      check("same_stall", stall, 1);
      step();
      exp_cnt++;
    end
    check("same_issue", issue, 1);
    check("same_fwd_a", fwd_a, 0);
    check("same_fwd_b", fwd_b, 0);
`endif
    step();

    // Youngest writer wins: two writes of r9, then read r9
    drain();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0);
    step();
    step();
    set_id(1'b1, 9, 1'b1, 1, 1'b0, 10, 1'b1, 1'b0);
`ifdef HAZARD_FWD_EN
    check("young_issue", issue, 1);
    check("young_fwd_a", fwd_a, 1);
`else
    for (int i = 0; i < 3; i++) begin
      check("young_stall", stall, 1);
      step();
      exp_cnt++;
    end
    check("young_issue", issue, 1);
    check("young_fwd_a", fwd_a, 0);
`endif
    step();
    check("young_cnt", stall_cnt, sat(exp_cnt));

    // Operand not read: no dependency
    drain();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 10, 1'b1, 1'b0);
    step();
    set_id(1'b1, 10, 1'b0, 10, 1'b0, 11, 1'b1, 1'b0);
    check("nouse_issue", issue, 1);
    check("nouse_stall", stall, 0);
    check("nouse_fwd_a", fwd_a, 0);
    step();

    // Flush on the load-use stall cycle
    drain();
    set_id(1'b1, 1, 1'b0, 0, 1'b0, 4, 1'b1, 1'b1);
    step();
    flush = 1'b1;
    set_id(1'b1, 4, 1'b1, 1, 1'b1, 7, 1'b1, 1'b0);
    check("flush_issue", issue, 0);
    check("flush_stall", stall, 0);
    step();
    flush = 1'b0;
    set_id(1'b1, 4, 1'b1, 1, 1'b1, 7, 1'b1, 1'b0);
    check("postflush_issue", issue, 1);
    check("postflush_stall", stall, 0);
    check("postflush_fwd_a", fwd_a, 0);
    check("postflush_cnt", stall_cnt, sat(exp_cnt));
    step();

    // Reset with three valid entries and a dependent instruction waiting
    drain();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 11, 1'b1, 1'b1);
    step();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 12, 1'b1, 1'b0);
    step();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 13, 1'b1, 1'b0);
    step();
    set_id(1'b1, 13, 1'b1, 11, 1'b1, 14, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    exp_cnt = 0;
    check("prst_stall", stall, 0);
    check("prst_cnt", stall_cnt, 0);
    check("prst_issue", issue, 1);
    check("prst_fwd_a", fwd_a, 0);
    check("prst_fwd_b", fwd_b, 0);
    step();

    // Saturation: repeat load-use pairs until at least 20 stall cycles
    drain();
    total = 0;
    iter  = 0;
    while (total < 20 && iter < 30) begin
      iter++;
      set_id(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b1);
      step();
      set_id(1'b1, 4, 1'b1, 0, 1'b0, 7, 1'b1, 1'b0);
      n = 0;
      while (stall && n < 10) begin
        n++;
        step();
      end
      check("sat_issue", issue, 1);
      total += n;
      step();
    end
    check("sat_total_reached", (total >= 20) ? 1 : 0, 1);
    check("sat_cnt", stall_cnt, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
